// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
//
// Purpose:
//   Bundles the signals exchanged between the pipeline datapath and the
//   hazard/stall controller. The datapath (master) supplies the decode and
//   stage information. The controller (slave) returns the stall, bubble and
//   flush controls and the stall-cycle statistic.
//
// Signals (names kept from the controller's point of view):
//   start_i          pipeline run enable
//   ifid_rs_i/rt_i   source register fields of the instruction in ID
//   idex_memread_i   instruction in EX is a load
//   idex_rt_i        destination register of the instruction in EX
//   branch_taken_i   branch in ID resolved taken
//   mem_req_i        load/store present in MEM
//   hazard_o         hold PC and IF/ID
//   idex_bubble_o    write NOP control into ID/EX
//   ifid_flush_o     clear IF/ID to NOP
//   mem_stall_o      freeze ID/EX, EX/MEM, MEM/WB
//   stall_cnt_o      saturating count of cycles with hazard_o=1
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             hazard_o;
    logic             idex_bubble_o;
    logic             ifid_flush_o;
    logic             mem_stall_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output start_i, ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_req_i,
        input  hazard_o, idex_bubble_o, ifid_flush_o, mem_stall_o, stall_cnt_o
    );

    modport slave (
        input  start_i, ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, mem_req_i,
        output hazard_o, idex_bubble_o, ifid_flush_o, mem_stall_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Producer of the PC/IF-ID stall controls. Detects load-use hazards and
//   taken-branch flushes. Runs a two-state wait FSM that freezes the back
//   end of the pipe while a fixed-latency data memory access completes.
//   Keeps a saturating count of stall cycles.
//
// Parameters:
//   MEM_LAT  data-memory latency in cycles (>=1); each access stalls
//            MEM_LAT-1 cycles
//   CNT_W    width of the stall-cycle counter
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous reset, active-low
//   bus      hazard_stall_ctrl_if.slave (see interface header)
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_stall_ctrl_if.slave bus
);
    localparam int WCNT_W   = $clog2(MEM_LAT) + 1;
    localparam bit HAS_WAIT = (MEM_LAT > 1);
    // In the first stall cycle, the FSM is still in IDLE. Loading MEM_LAT-2
    // gives MEM_LAT-1 stall cycles in total.
    localparam logic [WCNT_W-1:0] WCNT_LOAD = HAS_WAIT ? WCNT_W'(MEM_LAT - 2) : '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mem_stall;
    logic active;
    logic hazard;
    logic bubble;
    logic flush;

    // NOTE: every signal assigned here gets a default value first, so no
    // path through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        load_use = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                   ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));

        // Reset is folded in so that the combinational hazard paths also read 0
        // while the pipe is held in reset, not only the state-derived stall.
        active = rst_i && bus.start_i;

        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_stall = 1'b0;

        if (!bus.start_i) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mem_req_i && HAS_WAIT) begin
                        mem_stall = 1'b1;
                        state_d   = ST_WAIT;
                        wcnt_d    = WCNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q != '0) begin
                        mem_stall = 1'b1;
                        wcnt_d    = wcnt_q - WCNT_W'(1);
                    end else begin
                        // Release cycle: the finishing access is still leaving
                        // MEM, so its mem_req_i must not start a new access.
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end
            endcase
        end

        // Priority order: memory stall, then load-use, then branch flush.
        hazard = active && (mem_stall || load_use);
        bubble = active && !mem_stall && load_use;
        flush  = active && !mem_stall && !load_use && bus.branch_taken_i;

        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.hazard_o      = hazard;
    assign bus.idex_bubble_o = bubble;
    assign bus.ifid_flush_o  = flush;
    assign bus.mem_stall_o   = active && mem_stall;
    assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Three controllers with MEM_LAT = 4, 3, 1 share one stimulus stream. The
// MEM_LAT=3 instance has a 4-bit counter so that saturation can be reached.
// Expected outputs come from a model that tracks each memory access by the
// absolute cycle number at which the access releases the pipe.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic       branch;
    logic       mem_req;

    int n_checks = 0;
    int n_errors = 0;

    hazard_stall_ctrl_if #(.CNT_W(32)) if4 ();
    hazard_stall_ctrl_if #(.CNT_W(4))  if3 ();
    hazard_stall_ctrl_if #(.CNT_W(32)) if1 ();

    assign if4.start_i = start;          assign if3.start_i = start;          assign if1.start_i = start;
    assign if4.ifid_rs_i = ifid_rs;      assign if3.ifid_rs_i = ifid_rs;      assign if1.ifid_rs_i = ifid_rs;
    assign if4.ifid_rt_i = ifid_rt;      assign if3.ifid_rt_i = ifid_rt;      assign if1.ifid_rt_i = ifid_rt;
    assign if4.idex_memread_i = idex_memread;
    assign if3.idex_memread_i = idex_memread;
    assign if1.idex_memread_i = idex_memread;
    assign if4.idex_rt_i = idex_rt;      assign if3.idex_rt_i = idex_rt;      assign if1.idex_rt_i = idex_rt;
    assign if4.branch_taken_i = branch;  assign if3.branch_taken_i = branch;  assign if1.branch_taken_i = branch;
    assign if4.mem_req_i = mem_req;      assign if3.mem_req_i = mem_req;      assign if1.mem_req_i = mem_req;

    hazard_stall_ctrl #(.MEM_LAT(4), .CNT_W(32)) u4 (.clk_i(clk), .rst_i(rst_n), .bus(if4));
    hazard_stall_ctrl #(.MEM_LAT(3), .CNT_W(4))  u3 (.clk_i(clk), .rst_i(rst_n), .bus(if3));
    hazard_stall_ctrl #(.MEM_LAT(1), .CNT_W(32)) u1 (.clk_i(clk), .rst_i(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int     lat [3]  = '{4, 3, 1};
    longint cmax [3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};

    bit     acc_on  [3];
    int     acc_end [3];
    int     cyc;
    longint exp_cnt [3];
    logic [3:0] exp_bits [3];   // {hazard, bubble, flush, mem_stall}
    logic [3:0] obs_bits [3];
    longint     obs_cnt  [3];

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            acc_on[k]  = 1'b0;
            acc_end[k] = 0;
            exp_cnt[k] = 0;
        end
    endtask

    function automatic bit model_stall(int k);
        if (!rst_n || !start) return 1'b0;
        if (acc_on[k]) return (cyc < acc_end[k]);
        return mem_req && (lat[k] > 1);
    endfunction

    // Computes expectations and captures DUT outputs on the falling edge.
    task automatic sample();
        bit lu;
        @(negedge clk);
        lu = idex_memread && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || !start) exp_bits[k] = 4'b0000;
            else if (model_stall(k)) exp_bits[k] = 4'b1001;
            else if (lu) exp_bits[k] = 4'b1100;
            else if (branch) exp_bits[k] = 4'b0010;
            else exp_bits[k] = 4'b0000;
        end
        obs_bits[0] = {if4.hazard_o, if4.idex_bubble_o, if4.ifid_flush_o, if4.mem_stall_o};
        obs_bits[1] = {if3.hazard_o, if3.idex_bubble_o, if3.ifid_flush_o, if3.mem_stall_o};
        obs_bits[2] = {if1.hazard_o, if1.idex_bubble_o, if1.ifid_flush_o, if1.mem_stall_o};
        obs_cnt[0] = longint'(if4.stall_cnt_o);
        obs_cnt[1] = longint'(if3.stall_cnt_o);
        obs_cnt[2] = longint'(if1.stall_cnt_o);
    endtask

    // Advances the model across one rising edge; inputs change 1 ns later.
    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                acc_on[k]  = 1'b0;
                exp_cnt[k] = 0;
            end else if (!start) begin
                acc_on[k] = 1'b0;
            end else begin
                if (exp_bits[k][3] && exp_cnt[k] < cmax[k]) exp_cnt[k]++;
                if (acc_on[k] && cyc == acc_end[k]) acc_on[k] = 1'b0;
                else if (!acc_on[k] && mem_req && lat[k] > 1) begin
                    acc_on[k]  = 1'b1;
                    acc_end[k] = cyc + lat[k] - 1;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs = 0; ifid_rt = 0; idex_memread = 0; idex_rt = 0;
        branch = 0; mem_req = 0;
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        idex_memread = 1; idex_rt = 8; ifid_rs = 8; ifid_rt = 0; branch = 1; mem_req = 1;
        reset_model();
        cyc = 0;
        sample();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_bits[k] !== 4'b0000 || obs_cnt[k] !== 0) begin
                n_errors++;
                $display("FAIL reset dut%0d: got bits=%b cnt=%0d, expected bits=0000 cnt=0",
                         k, obs_bits[k], obs_cnt[k]);
            end
        end
        advance();
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_idle_run();
        for (int i = 0; i < 10; i++) begin
            sample();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_bits[k] !== exp_bits[k] || obs_cnt[k] !== 0) begin
                    n_errors++;
                    $display("FAIL idle_run dut%0d cyc%0d: got bits=%b cnt=%0d, expected bits=%b cnt=0",
                             k, i, obs_bits[k], obs_cnt[k], exp_bits[k]);
                end
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        logic [3:0] want [3];
        idex_memread = 1; idex_rt = 8; ifid_rs = 8; ifid_rt = 3;
        want = '{4'b1100, 4'b1100, 4'b0000};          // step 0: stall + bubble
        for (int step = 0; step < 3; step++) begin
            if (step == 1) idex_memread = 0;           // load moved on to MEM
            if (step == 2) begin
                idex_memread = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
            end
            sample();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_bits[k] !== exp_bits[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_errors++;
                    $display("FAIL load_use dut%0d step%0d: got bits=%b cnt=%0d, expected bits=%b cnt=%0d",
                             k, step, obs_bits[k], obs_cnt[k], exp_bits[k], exp_cnt[k]);
                end
            end
            n_checks++;
            if (obs_bits[0] !== (step == 0 ? want[0] : want[2])) begin
                n_errors++;
                $display("FAIL load_use_direct step%0d: got bits=%b, expected %b",
                         step, obs_bits[0], (step == 0 ? want[0] : want[2]));
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_mem_stall();
        logic [3:0] pat4;
        logic       any1;
        longint     base;
        pat4 = '0; any1 = 1'b0;
        base = exp_cnt[0];
        mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_bits[k] !== exp_bits[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_errors++;
                    $display("FAIL mem_stall dut%0d cyc%0d: got bits=%b cnt=%0d, expected bits=%b cnt=%0d",
                             k, i, obs_bits[k], obs_cnt[k], exp_bits[k], exp_cnt[k]);
                end
            end
            pat4[3-i] = obs_bits[0][0];
            any1 = any1 | obs_bits[2][0];
            advance();
        end
        mem_req = 0;
        sample();
        n_checks++;
        if (pat4 !== 4'b1110 || any1 !== 1'b0 || obs_cnt[0] !== base + 3) begin
            n_errors++;
            $display("FAIL mem_stall_pattern: got lat4=%b lat1_any=%b cnt_delta=%0d, expected 1110, 0, 3",
                     pat4, any1, obs_cnt[0] - base);
        end
        advance();
        clear_inputs();
        idle_cycles(4);
    endtask

    task automatic test_priority();
        // load-use beats branch
        idex_memread = 1; idex_rt = 5; ifid_rt = 5; branch = 1;
        sample();
        n_checks++;
        if (obs_bits[2] !== 4'b1100 || obs_bits[2] !== exp_bits[2]) begin
            n_errors++;
            $display("FAIL prio_loaduse_branch: got bits=%b, expected 1100", obs_bits[2]);
        end
        advance();
        // memory stall beats both: start an access, then look inside WAIT
        mem_req = 1;
        sample();
        advance();
        mem_req = 0;
        sample();
        n_checks++;
        if (obs_bits[0] !== 4'b1001 || obs_bits[0] !== exp_bits[0]) begin
            n_errors++;
            $display("FAIL prio_memstall: got bits=%b, expected 1001", obs_bits[0]);
        end
        advance();
        clear_inputs();
        idle_cycles(4);
        // branch alone
        branch = 1;
        sample();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_bits[k] !== 4'b0010 || obs_cnt[k] !== exp_cnt[k]) begin
                n_errors++;
                $display("FAIL prio_branch dut%0d: got bits=%b cnt=%0d, expected bits=0010 cnt=%0d",
                         k, obs_bits[k], obs_cnt[k], exp_cnt[k]);
            end
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat3;
        pat3 = '0;
        mem_req = 1;
        for (int i = 0; i < 6; i++) begin
            sample();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_bits[k] !== exp_bits[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_errors++;
                    $display("FAIL back_to_back dut%0d cyc%0d: got bits=%b cnt=%0d, expected bits=%b cnt=%0d",
                             k, i, obs_bits[k], obs_cnt[k], exp_bits[k], exp_cnt[k]);
                end
            end
            pat3[5-i] = obs_bits[1][0];
            advance();
        end
        n_checks++;
        if (pat3 !== 6'b110110) begin
            n_errors++;
            $display("FAIL back_to_back_pattern: got %b, expected 110110", pat3);
        end
        clear_inputs();
        idle_cycles(4);
    endtask

    task automatic test_saturation();
        idex_memread = 1; idex_rt = 9; ifid_rs = 9;
        for (int i = 0; i < 20; i++) begin
            sample();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_bits[k] !== exp_bits[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_errors++;
                    $display("FAIL saturation dut%0d cyc%0d: got bits=%b cnt=%0d, expected bits=%b cnt=%0d",
                             k, i, obs_bits[k], obs_cnt[k], exp_bits[k], exp_cnt[k]);
                end
            end
            advance();
        end
        sample();
        n_checks++;
        if (obs_cnt[1] !== 15) begin
            n_errors++;
            $display("FAIL saturation_hold: got cnt=%0d, expected 15", obs_cnt[1]);
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_start_low();
        longint held [3];
        mem_req = 1;
        sample();
        advance();
        mem_req = 0;
        start = 0;
        idex_memread = 1; idex_rt = 4; ifid_rs = 4; branch = 1;
        for (int k = 0; k < 3; k++) held[k] = exp_cnt[k];
        for (int i = 0; i < 4; i++) begin
            sample();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_bits[k] !== 4'b0000 || obs_cnt[k] !== held[k]) begin
                    n_errors++;
                    $display("FAIL start_low dut%0d cyc%0d: got bits=%b cnt=%0d, expected bits=0000 cnt=%0d",
                             k, i, obs_bits[k], obs_cnt[k], held[k]);
                end
            end
            advance();
        end
        // FSM was forced to IDLE, so re-enabling shows no leftover stall.
        start = 1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            sample();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_bits[k] !== exp_bits[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_errors++;
                    $display("FAIL start_resume dut%0d: got bits=%b cnt=%0d, expected bits=%b cnt=%0d",
                             k, obs_bits[k], obs_cnt[k], exp_bits[k], exp_cnt[k]);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start        = ($urandom_range(0, 9) != 0);
            idex_memread = ($urandom_range(0, 2) == 0);
            idex_rt      = 5'($urandom_range(0, 3));
            ifid_rs      = 5'($urandom_range(0, 3));
            ifid_rt      = 5'($urandom_range(0, 3));
            branch       = ($urandom_range(0, 3) == 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            sample();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_bits[k] !== exp_bits[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    n_errors++;
                    $display("FAIL random dut%0d cyc%0d: got bits=%b cnt=%0d, expected bits=%b cnt=%0d",
                             k, i, obs_bits[k], obs_cnt[k], exp_bits[k], exp_cnt[k]);
                end
            end
            advance();
        end
        start = 1;
        clear_inputs();
        idle_cycles(4);
    endtask

    task automatic test_reset_mid_wait();
        mem_req = 1;
        sample();
        advance();
        mem_req = 0;
        sample();                                  // lat4 instance is now in WAIT
        n_checks++;
        if (obs_bits[0] !== 4'b1001) begin
            n_errors++;
            $display("FAIL reset_mid_wait_pre: got bits=%b, expected 1001", obs_bits[0]);
        end
        idex_memread = 1; idex_rt = 7; ifid_rt = 7; branch = 1;
        #2 rst_n = 1'b0;
        #1;
        obs_bits[0] = {if4.hazard_o, if4.idex_bubble_o, if4.ifid_flush_o, if4.mem_stall_o};
        obs_bits[1] = {if3.hazard_o, if3.idex_bubble_o, if3.ifid_flush_o, if3.mem_stall_o};
        obs_bits[2] = {if1.hazard_o, if1.idex_bubble_o, if1.ifid_flush_o, if1.mem_stall_o};
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_bits[k] !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_mid_wait dut%0d: got bits=%b, expected 0000", k, obs_bits[k]);
            end
        end
        n_checks++;
        if (if4.stall_cnt_o !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_mid_wait_cnt: got %0d, expected 0", if4.stall_cnt_o);
        end
        reset_model();
        advance();
        rst_n = 1'b1;
        clear_inputs();
        sample();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_bits[k] !== 4'b0000 || obs_cnt[k] !== 0) begin
                n_errors++;
                $display("FAIL reset_release dut%0d: got bits=%b cnt=%0d, expected bits=0000 cnt=0",
                         k, obs_bits[k], obs_cnt[k]);
            end
        end
        advance();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_idle_run();
        test_load_use();
        test_mem_stall();
        test_priority();
        test_back_to_back();
        test_saturation();
        test_start_low();
        test_random();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
